// File: rtl/mem_access_unit.sv
// Memory-stage access unit: issues aligned loads/stores to the data port, stalls upstream
// until the response arrives, and passes non-memory ops and misaligned ops straight through.
package mem_access_unit_pkg;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       msign;
    logic [2:0] msize;
  } ctl_t;

  typedef struct packed {
    logic [XLEN-1:0]   result;
    logic [XLEN-1:0]   pc;
    ctl_t              ctl;
    logic [REG_AW-1:0] dst;
    logic              is_bubble;
  } execute_data_t;

  typedef struct packed {
    logic [XLEN-1:0]   result;
    logic [XLEN-1:0]   pc;
    ctl_t              ctl;
    logic [REG_AW-1:0] dst;
    logic              is_bubble;
    logic              misalign;
  } memory_data_t;
endpackage

module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  execute_data_t   dataE,
  input  logic [XLEN-1:0] wdata,
  output logic            dreq_valid,
  output logic [XLEN-1:0] dreq_addr,
  output logic [2:0]      dreq_size,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_data,
  input  logic            dresp_ok,
  input  logic [XLEN-1:0] dresp_data,
  output memory_data_t    dataM,
  output logic            Dwait
);

  localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [2:0]      size_q, size_d;
  logic            sign_q, sign_d;
  logic [7:0]      strobe_q, strobe_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] resp_buf_q, resp_buf_d;

  logic            is_mem, misalign;
  logic [2:0]      offset;
  logic [7:0]      base_strobe, req_strobe;
  logic [XLEN-1:0] req_data;
  logic [2:0]      ext_off, ext_size;
  logic            ext_sign;
  logic [XLEN-1:0] shifted, ext_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      sign_q     <= 1'b0;
      strobe_q   <= '0;
      data_q     <= '0;
      resp_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      sign_q     <= sign_d;
      strobe_q   <= strobe_d;
      data_q     <= data_d;
      resp_buf_q <= resp_buf_d;
    end
  end

  // Request decode from the incoming op: alignment, byte lanes, lane-shifted store data
  always_comb begin
    is_mem = !dataE.is_bubble && (dataE.ctl.memread || dataE.ctl.memwrite);
    offset = dataE.result[2:0];
    case (dataE.ctl.msize)
      3'd1:    misalign = offset[0];
      3'd2:    misalign = |offset[1:0];
      3'd3:    misalign = |offset;
      default: misalign = 1'b0;
    endcase
    case (dataE.ctl.msize)
      3'd0:    base_strobe = 8'h01;
      3'd1:    base_strobe = 8'h03;
      3'd2:    base_strobe = 8'h0F;
      3'd3:    base_strobe = 8'hFF;
      default: base_strobe = 8'h00;
    endcase
    req_strobe = dataE.ctl.memwrite ? (base_strobe << offset) : 8'h00;
    req_data   = wdata << {offset, 3'b000};
  end

  // Load extraction uses the live op in the issue cycle and the latched request afterwards
  always_comb begin
    ext_off  = (state_q == IDLE) ? offset : addr_q[2:0];
    ext_size = (state_q == IDLE) ? dataE.ctl.msize : size_q;
    ext_sign = (state_q == IDLE) ? dataE.ctl.msign : sign_q;
    shifted  = dresp_data >> {ext_off, 3'b000};
    case (ext_size)
      3'd0:    ext_val = ext_sign ? {{56{shifted[7]}}, shifted[7:0]}   : {56'd0, shifted[7:0]};
      3'd1:    ext_val = ext_sign ? {{48{shifted[15]}}, shifted[15:0]} : {48'd0, shifted[15:0]};
      3'd2:    ext_val = ext_sign ? {{32{shifted[31]}}, shifted[31:0]} : {32'd0, shifted[31:0]};
      default: ext_val = shifted;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    sign_d      = sign_q;
    strobe_d    = strobe_q;
    data_d      = data_q;
    resp_buf_d  = resp_buf_q;
    dreq_valid  = 1'b0;
    dreq_addr   = addr_q;
    dreq_size   = size_q;
    dreq_strobe = strobe_q;
    dreq_data   = data_q;
    Dwait       = 1'b0;
    dataM = '{result: dataE.result, pc: dataE.pc, ctl: dataE.ctl, dst: dataE.dst,
              is_bubble: dataE.is_bubble, misalign: 1'b0};

    case (state_q)
      IDLE: begin
        if (is_mem && misalign) begin
          dataM.misalign     = 1'b1;
          dataM.ctl.regwrite = 1'b0;
        end else if (is_mem) begin
          dreq_valid  = 1'b1;
          dreq_addr   = dataE.result;
          dreq_size   = dataE.ctl.msize;
          dreq_strobe = req_strobe;
          dreq_data   = req_data;
          Dwait       = 1'b1;
          addr_d      = dataE.result;
          size_d      = dataE.ctl.msize;
          sign_d      = dataE.ctl.msign;
          strobe_d    = req_strobe;
          data_d      = req_data;
          dataM = '{result: '0, pc: dataE.pc, ctl: '0, dst: '0, is_bubble: 1'b1, misalign: 1'b0};
          if (dresp_ok) begin
            resp_buf_d = ext_val;
            state_d    = DONE;
          end else begin
            state_d    = BUSY;
          end
        end
      end
      BUSY: begin
        dreq_valid = 1'b1;
        Dwait      = 1'b1;
        dataM = '{result: '0, pc: dataE.pc, ctl: '0, dst: '0, is_bubble: 1'b1, misalign: 1'b0};
        if (dresp_ok) begin
          resp_buf_d = ext_val;
          state_d    = DONE;
        end
      end
      DONE: begin
        dataM.result = resp_buf_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset overrides the visible outputs in the same cycle
    if (reset) begin
      dreq_valid = 1'b0;
      Dwait      = 1'b0;
      dataM = '{result: '0, pc: RESET_PC, ctl: '0, dst: '0, is_bubble: 1'b1, misalign: 1'b0};
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed corner cases followed by random ops checked against
// a byte-level reference model of the data port.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  execute_data_t dataE;
  logic [63:0]   wdata;
  logic          dreq_valid;
  logic [63:0]   dreq_addr;
  logic [2:0]    dreq_size;
  logic [7:0]    dreq_strobe;
  logic [63:0]   dreq_data;
  logic          dresp_ok;
  logic [63:0]   dresp_data;
  memory_data_t  dataM;
  logic          Dwait;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .dataE(dataE), .wdata(wdata),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_ok(dresp_ok), .dresp_data(dresp_data), .dataM(dataM), .Dwait(Dwait)
  );

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic execute_data_t mk(input logic rd, input logic wr, input logic sg,
                                       input logic [2:0] sz, input logic [63:0] a,
                                       input logic bub);
    execute_data_t e;
    e.result       = a;
    e.pc           = 64'h8000_0000 + 64'($urandom_range(0, 4095)) * 64'd4;
    e.ctl.memread  = rd;
    e.ctl.memwrite = wr;
    e.ctl.regwrite = !wr;
    e.ctl.msign    = sg;
    e.ctl.msize    = sz;
    e.dst          = 5'($urandom);
    e.is_bubble    = bub;
    return e;
  endfunction

  // Reference: pick the addressed bytes out of the aligned word, then extend
  function automatic logic [63:0] exp_load(input logic [63:0] word, input int off,
                                           input int szc, input logic sgn);
    logic [63:0] v = '0;
    int n = 1 << szc;
    for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
    if (sgn && v[8*n-1]) for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] exp_strobe(input int off, input int szc, input logic wr);
    logic [7:0] s = '0;
    if (wr) for (int i = 0; i < (1 << szc); i++) s[off+i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] exp_wdata(input logic [63:0] wd, input int off);
    logic [63:0] d = '0;
    for (int b = 0; b < 8; b++) if (b >= off) d[8*b +: 8] = wd[8*(b-off) +: 8];
    return d;
  endfunction

  // Runs one op; n = cycles the request stays outstanding, dresp_ok in the last of them
  task automatic run_op(input execute_data_t e, input logic [63:0] wd,
                        input logic [63:0] rd, input int n);
    memory_data_t exp;
    logic mem, al;
    int szc, off;
    mem = !e.is_bubble && (e.ctl.memread || e.ctl.memwrite);
    szc = int'(e.ctl.msize);
    off = int'(e.result[2:0]);
    al  = (off % (1 << szc)) == 0;
    exp = '{result: e.result, pc: e.pc, ctl: e.ctl, dst: e.dst,
            is_bubble: e.is_bubble, misalign: 1'b0};
    @(negedge clk);
    dataE      = e;
    wdata      = wd;
    dresp_ok   = 1'b0;
    dresp_data = {$urandom, $urandom};
    if (!mem || !al) begin
      if (mem) begin
        exp.misalign     = 1'b1;
        exp.ctl.regwrite = 1'b0;
      end
      #1;
      chk("pass_dreq_valid", 192'(dreq_valid), 192'(1'b0));
      chk("pass_dwait", 192'(Dwait), 192'(1'b0));
      chk("pass_dataM", 192'(dataM), 192'(exp));
    end else begin
      for (int i = 0; i < n; i++) begin
        if (i > 0) begin
          @(negedge clk);
          wdata = {$urandom, $urandom};
        end
        dresp_ok   = (i == n - 1);
        dresp_data = (i == n - 1) ? rd : {$urandom, $urandom};
        #1;
        chk("req_valid", 192'(dreq_valid), 192'(1'b1));
        chk("req_dwait", 192'(Dwait), 192'(1'b1));
        chk("req_addr", 192'(dreq_addr), 192'(e.result));
        chk("req_size", 192'(dreq_size), 192'(e.ctl.msize));
        chk("req_strobe", 192'(dreq_strobe), 192'(exp_strobe(off, szc, e.ctl.memwrite)));
        chk("req_data", 192'(dreq_data), 192'(exp_wdata(wd, off)));
        chk("req_bubble", 192'(dataM.is_bubble), 192'(1'b1));
      end
      @(negedge clk);
      dresp_ok   = 1'($urandom);
      dresp_data = {$urandom, $urandom};
      exp.result = exp_load(rd, off, szc, e.ctl.msign);
      #1;
      chk("done_dwait", 192'(Dwait), 192'(1'b0));
      chk("done_dreq_valid", 192'(dreq_valid), 192'(1'b0));
      chk("done_dataM", 192'(dataM), 192'(exp));
    end
  endtask

  initial begin
    execute_data_t e;
    memory_data_t  rst_exp;
    rst_exp = '{result: '0, pc: 64'h8000_0000, ctl: '0, dst: '0, is_bubble: 1'b1, misalign: 1'b0};
    reset      = 1'b1;
    dataE      = mk(1'b1, 1'b0, 1'b0, 3'd3, 64'h8000_1000, 1'b0);
    wdata      = '0;
    dresp_ok   = 1'b0;
    dresp_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_dreq_valid", 192'(dreq_valid), 192'(1'b0));
    chk("rst_dwait", 192'(Dwait), 192'(1'b0));
    chk("rst_dataM", 192'(dataM), 192'(rst_exp));
    @(posedge clk);
    reset = 1'b0;

    // LD with three stall cycles, then an ALU op right behind it
    run_op(mk(1'b1, 1'b0, 1'b0, 3'd3, 64'h8000_1000, 1'b0), '0, 64'h1122334455667788, 3);
    chk("ld_value", 192'(dataM.result), 192'(64'h1122334455667788));
    run_op(mk(1'b0, 1'b0, 1'b0, 3'd0, 64'h0000_1234_5678_9ABC, 1'b0), '0, '0, 1);
    // LB signed and LBU on byte 0x80
    run_op(mk(1'b1, 1'b0, 1'b1, 3'd0, 64'h8000_1003, 1'b0), '0, 64'h0000_0000_8000_0000, 2);
    chk("lb_value", 192'(dataM.result), 192'(64'hFFFF_FFFF_FFFF_FF80));
    run_op(mk(1'b1, 1'b0, 1'b0, 3'd0, 64'h8000_1003, 1'b0), '0, 64'h0000_0000_8000_0000, 1);
    chk("lbu_value", 192'(dataM.result), 192'(64'h80));
    // SH into the top halfword
    run_op(mk(1'b0, 1'b1, 1'b0, 3'd1, 64'h8000_1006, 1'b0), 64'hABCD, '0, 3);
    // Misaligned LW and a bubble
    run_op(mk(1'b1, 1'b0, 1'b1, 3'd2, 64'h8000_1002, 1'b0), '0, '0, 1);
    run_op(mk(1'b1, 1'b0, 1'b0, 3'd3, 64'h8000_1000, 1'b1), '0, '0, 1);

    // Reset while BUSY, then a stale response
    @(negedge clk);
    dataE = mk(1'b1, 1'b0, 1'b0, 3'd3, 64'h8000_2000, 1'b0);
    dresp_ok = 1'b0;
    #1;
    chk("abort_issue", 192'(dreq_valid), 192'(1'b1));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_rst_valid", 192'(dreq_valid), 192'(1'b0));
    chk("abort_rst_dwait", 192'(Dwait), 192'(1'b0));
    chk("abort_rst_dataM", 192'(dataM), 192'(rst_exp));
    @(negedge clk);
    reset    = 1'b0;
    e        = mk(1'b0, 1'b0, 1'b0, 3'd0, '0, 1'b1);
    e.pc     = 64'h8000_0000;
    dataE    = e;
    dresp_ok = 1'b1;
    #1;
    chk("stale_valid", 192'(dreq_valid), 192'(1'b0));
    chk("stale_dwait", 192'(Dwait), 192'(1'b0));
    chk("stale_bubble", 192'(dataM.is_bubble), 192'(1'b1));
    chk("stale_pc", 192'(dataM.pc), 192'(64'h8000_0000));
    @(negedge clk);
    dataE = mk(1'b0, 1'b0, 1'b0, 3'd0, 64'h55, 1'b0);
    #1;
    chk("stale_alu", 192'(dataM.result), 192'(64'h55));
    chk("stale_alu_dwait", 192'(Dwait), 192'(1'b0));

    // Random mix of ALU ops, loads and stores
    for (int k = 0; k < 60; k++) begin
      int kind;
      logic [63:0] a;
      kind = $urandom_range(0, 2);
      a    = 64'h8000_1000 + 64'($urandom_range(0, 63) * 8) + 64'($urandom_range(0, 7));
      if (kind == 0) e = mk(1'b0, 1'b0, 1'b0, 3'd0, {$urandom, $urandom}, 1'($urandom));
      else e = mk(kind == 1, kind == 2, 1'($urandom), 3'($urandom_range(0, 3)), a, 1'b0);
      run_op(e, {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(1, 4));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
